// File: rtl/lmring_term.sv
// lmring_term: head/tail terminator of the LMM ring.
//   Packs host requests into LMRING_BR packets toward the first ring stage, retires
//   packets returning from the last stage and hands read data / write acks back.
//   Checks in-order sequence numbers and that some unit claimed each packet (AV).
// Ports:
//   ACLK, RST                      clock, async active-high reset
//   req_*                          host request (val/rdy, rw, ty, col, a, dm, d)
//   lmring_bout_nemp/bout/bout_ful packet toward first stage
//   lmring_bin_nemp/bin/bin_ful    packet from last stage
//   rsp_*                          host response (val/rdy, rw, d)
//   drain, drain_done              stop issue and wait for an empty ring
//   err_av, err_sq                 sticky: unclaimed packet, sequence error
//   outst                          packets in flight
// Optional: LMRING_TERM_TIMEOUT_EN adds a watchdog and the err_tmo output.

`ifndef LMRING_BR_BITS
`define LMRING_DATA_BITS 32
`define LMRING_BR_BITS   118
`define LMRING_BR_D      31:0
`define LMRING_BR_DM     63:32
`define LMRING_BR_A      94:64
`define LMRING_BR_AV     95
`define LMRING_BR_SQ     111:96
`define LMRING_BR_SQ_W   16
`define LMRING_BR_COL    113:112
`define LMRING_BR_TY     116:114
`define LMRING_BR_RW     117
`endif

module lmring_term #(
  parameter int unsigned MAX_OUTST = 8,
  parameter int unsigned SQ_W      = 16,
  parameter int unsigned TMO_CYC   = 1024
) (
  input  logic                          ACLK,
  input  logic                          RST,
  input  logic                          req_val,
  output logic                          req_rdy,
  input  logic                          req_rw,
  input  logic [2:0]                    req_ty,
  input  logic [1:0]                    req_col,
  input  logic [30:0]                   req_a,
  input  logic [31:0]                   req_dm,
  input  logic [`LMRING_DATA_BITS-1:0]  req_d,
  output logic                          lmring_bout_nemp,
  output logic [`LMRING_BR_BITS-1:0]    lmring_bout,
  input  logic                          lmring_bout_ful,
  input  logic                          lmring_bin_nemp,
  input  logic [`LMRING_BR_BITS-1:0]    lmring_bin,
  output logic                          lmring_bin_ful,
  output logic                          rsp_val,
  input  logic                          rsp_rdy,
  output logic                          rsp_rw,
  output logic [`LMRING_DATA_BITS-1:0]  rsp_d,
  input  logic                          drain,
  output logic                          drain_done,
  output logic                          err_av,
  output logic                          err_sq,
  output logic [7:0]                    outst
`ifdef LMRING_TERM_TIMEOUT_EN
  , output logic                        err_tmo
`endif
);

  localparam int unsigned DW = `LMRING_DATA_BITS;
  localparam int unsigned BW = `LMRING_BR_BITS;

  // Elaboration-time sanity of the parameter set
  if (MAX_OUTST < 1 || MAX_OUTST > 255 || SQ_W != `LMRING_BR_SQ_W ||
      TMO_CYC < 1 || TMO_CYC > 65535) begin : g_param_err
    $error("lmring_term: illegal parameter set");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [SQ_W-1:0] sq_tx_q, sq_tx_d, sq_rx_q, sq_rx_d;
  logic [7:0]      outst_q, outst_d;
  logic            bout_nemp_q, bout_nemp_d;
  logic [BW-1:0]   bout_q, bout_d;
  logic            rsp_val_q, rsp_val_d, rsp_rw_q, rsp_rw_d;
  logic [DW-1:0]   rsp_d_q, rsp_d_d;
  logic            err_av_q, err_av_d, err_sq_q, err_sq_d;
`ifdef LMRING_TERM_TIMEOUT_EN
  logic [15:0]     wdog_q, wdog_d;
  logic            err_tmo_q, err_tmo_d;
`endif

  logic            issue_c, take_c;
  logic [SQ_W-1:0] bin_sq_c;
  logic            unused_bin_c;

  // Issue may reuse the output slot in the same cycle it drains
  assign req_rdy        = (state_q == ST_RUN) && (outst_q < 8'(MAX_OUTST)) &&
                          (!bout_nemp_q || !lmring_bout_ful);
  assign lmring_bin_ful = rsp_val_q && !rsp_rdy;
  assign issue_c        = req_val && req_rdy;
  assign take_c         = lmring_bin_nemp && !lmring_bin_ful;
  assign bin_sq_c       = lmring_bin[`LMRING_BR_SQ];
  assign unused_bin_c   = ^{lmring_bin[`LMRING_BR_TY], lmring_bin[`LMRING_BR_COL],
                            lmring_bin[`LMRING_BR_A], lmring_bin[`LMRING_BR_DM]};

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    sq_tx_d     = sq_tx_q;
    sq_rx_d     = sq_rx_q;
    outst_d     = outst_q;
    bout_nemp_d = bout_nemp_q;
    bout_d      = bout_q;
    rsp_val_d   = rsp_val_q;
    rsp_rw_d    = rsp_rw_q;
    rsp_d_d     = rsp_d_q;
    err_av_d    = err_av_q;
    err_sq_d    = err_sq_q;
`ifdef LMRING_TERM_TIMEOUT_EN
    wdog_d      = wdog_q;
    err_tmo_d   = err_tmo_q;
`endif

    // Injection side
    if (issue_c) begin
      bout_nemp_d = 1'b1;
      bout_d      = {req_rw, req_ty, req_col, sq_tx_q, 1'b0, req_a, req_dm, req_d};
      sq_tx_d     = sq_tx_q + SQ_W'(1);
    end else if (bout_nemp_q && !lmring_bout_ful) begin
      bout_nemp_d = 1'b0;
    end

    // Retire side: single response register
    if (take_c) begin
      rsp_val_d = 1'b1;
      rsp_rw_d  = lmring_bin[`LMRING_BR_RW];
      rsp_d_d   = lmring_bin[`LMRING_BR_RW] ? '0 : lmring_bin[`LMRING_BR_D];
      sq_rx_d   = bin_sq_c + SQ_W'(1);
      if (bin_sq_c != sq_rx_q || outst_q == 8'd0) err_sq_d = 1'b1;
      if (!lmring_bin[`LMRING_BR_AV]) err_av_d = 1'b1;
    end else if (rsp_rdy) begin
      rsp_val_d = 1'b0;
    end

    // In-flight count; a stray retire at zero is clamped
    if (issue_c && !take_c)                         outst_d = outst_q + 8'd1;
    else if (take_c && !issue_c && outst_q != 8'd0) outst_d = outst_q - 8'd1;

    unique case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain) state_d = ST_RUN;
        else if (outst_q == 8'd0 && !bout_nemp_q && !rsp_val_q) state_d = ST_DONE;
      end
      ST_DONE:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

`ifdef LMRING_TERM_TIMEOUT_EN
    // Watchdog: abandon in-flight packets after TMO_CYC silent cycles
    if (take_c || outst_q == 8'd0) begin
      wdog_d = '0;
    end else if (wdog_q == 16'(TMO_CYC - 1)) begin
      wdog_d    = '0;
      err_tmo_d = 1'b1;
      state_d   = ST_DONE;
      outst_d   = '0;
      sq_rx_d   = sq_tx_d;
    end else begin
      wdog_d = wdog_q + 16'd1;
    end
`endif
  end

  // State registers
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      sq_tx_q     <= '0;
      sq_rx_q     <= '0;
      outst_q     <= '0;
      bout_nemp_q <= 1'b0;
      bout_q      <= '0;
      rsp_val_q   <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_d_q     <= '0;
      err_av_q    <= 1'b0;
      err_sq_q    <= 1'b0;
`ifdef LMRING_TERM_TIMEOUT_EN
      wdog_q      <= '0;
      err_tmo_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sq_tx_q     <= sq_tx_d;
      sq_rx_q     <= sq_rx_d;
      outst_q     <= outst_d;
      bout_nemp_q <= bout_nemp_d;
      bout_q      <= bout_d;
      rsp_val_q   <= rsp_val_d;
      rsp_rw_q    <= rsp_rw_d;
      rsp_d_q     <= rsp_d_d;
      err_av_q    <= err_av_d;
      err_sq_q    <= err_sq_d;
`ifdef LMRING_TERM_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_tmo_q   <= err_tmo_d;
`endif
    end
  end

  assign lmring_bout_nemp = bout_nemp_q;
  assign lmring_bout      = bout_q;
  assign rsp_val          = rsp_val_q;
  assign rsp_rw           = rsp_rw_q;
  assign rsp_d            = rsp_d_q;
  assign err_av           = err_av_q;
  assign err_sq           = err_sq_q;
  assign outst            = outst_q;
  assign drain_done       = (state_q == ST_DONE);
`ifdef LMRING_TERM_TIMEOUT_EN
  assign err_tmo          = err_tmo_q;
`endif

endmodule
